// File: rtl/cnn_pkg.sv
// cnn_pkg -- shared defaults for the CNN feature-map blocks.
//   DW_DEF/ROWS_DEF/COLS_DEF/WIN_DEF : default word width, map size, window edge
//   win_state_e                      : window-read FSM states
package cnn_pkg;

    localparam int DW_DEF   = 18;
    localparam int ROWS_DEF = 26;
    localparam int COLS_DEF = 26;
    localparam int WIN_DEF  = 2;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RD    = 2'd1,
        ST_DRAIN = 2'd2,
        ST_OUT   = 2'd3
    } win_state_e;

endpackage

// File: rtl/fmap_win_ram_if.sv
// fmap_win_ram_if -- bus bundle for fmap_win_ram.
//   write side  : wr, addr_wr, din, frame_clr -> frame_full
//   request     : req_valid/req_ready, req_row/req_col (window top-left)
//   result      : win_valid/win_ready, win_data (lane k = r*WIN+c at [k*DW +: DW])
//   slave = the RAM block, master = the client driving it.
interface fmap_win_ram_if
    import cnn_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int WIN  = WIN_DEF
) ();
    localparam int N     = WIN * WIN;
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(ROWS + WIN);
    localparam int CW    = $clog2(COLS + WIN);

    logic              wr;
    logic [AW-1:0]     addr_wr;
    logic [DW-1:0]     din;
    logic              frame_clr;
    logic              frame_full;
    logic              req_valid;
    logic              req_ready;
    logic [RW-1:0]     req_row;
    logic [CW-1:0]     req_col;
    logic              win_valid;
    logic              win_ready;
    logic [N*DW-1:0]   win_data;

    modport slave (
        input  wr, addr_wr, din, frame_clr, req_valid, req_row, req_col, win_ready,
        output frame_full, req_ready, win_valid, win_data
    );

    modport master (
        output wr, addr_wr, din, frame_clr, req_valid, req_row, req_col, win_ready,
        input  frame_full, req_ready, win_valid, win_data
    );
endinterface

// File: rtl/fmap_ram_sp.sv
// fmap_ram_sp -- 1W1R feature-map storage, read-first, registered dout.
//   clk          : clock
//   we/waddr/wdata : write port
//   re/raddr     : read port, data appears on dout after the edge
// Storage and dout carry no reset; contents survive a block reset.
module fmap_ram_sp #(
    parameter int DW    = 18,
    parameter int DEPTH = 676,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic          re,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] dout
);
    logic [DW-1:0] mem [DEPTH];

    // Both ports in one process: the nonblocking write lands after the read
    // samples, so a same-edge collision returns the old word.
    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
        if (re) dout <= mem[raddr];
    end
endmodule

// File: rtl/fmap_win_ram.sv
// fmap_win_ram -- feature-map RAM with WINxWIN window read-out.
//   clk, rst : clock, async active-high reset
//   bus      : fmap_win_ram_if.slave (write port, frame counter,
//              window request / result handshakes)
// A request latches the top-left corner, issues N reads in lane order,
// captures each registered RAM word one cycle later, then presents the
// whole window until win_ready. Out-of-map lanes read as zero.
module fmap_win_ram
    import cnn_pkg::*;
#(
    parameter int DW   = DW_DEF,
    parameter int ROWS = ROWS_DEF,
    parameter int COLS = COLS_DEF,
    parameter int WIN  = WIN_DEF
) (
    input  logic          clk,
    input  logic          rst,
    fmap_win_ram_if.slave bus
);
    localparam int N     = WIN * WIN;
    localparam int DEPTH = ROWS * COLS;
    localparam int AW    = $clog2(DEPTH);
    localparam int RW    = $clog2(ROWS + WIN);
    localparam int CW    = $clog2(COLS + WIN);
    localparam int KW    = (N > 1) ? $clog2(N) : 1;
    localparam int CNTW  = $clog2(DEPTH + 1);

    win_state_e             state, state_nxt;
    logic [RW-1:0]          row_q;
    logic [CW-1:0]          col_q;
    logic [KW-1:0]          k_q;
    logic                   rd_vld;
    logic                   rd_pad;
    logic [KW-1:0]          rd_lane;
    logic [N-1:0][DW-1:0]   lane_q;
    logic [CNTW-1:0]        cnt_q;

    logic                   wr_ok;
    logic                   issue;
    int                     r_i, c_i;
    logic                   cur_pad;
    logic [AW-1:0]          rd_addr;
    logic [DW-1:0]          ram_dout;

    // ---------------- write side / frame counter ----------------
    assign wr_ok = bus.wr && (int'(bus.addr_wr) < DEPTH);

    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            cnt_q <= '0;
        else if (bus.frame_clr)
            cnt_q <= '0;
        else if (wr_ok && cnt_q != CNTW'(DEPTH))
            cnt_q <= cnt_q + 1'b1;
    end

    assign bus.frame_full = (cnt_q == CNTW'(DEPTH));

    // ---------------- read address for lane k_q ----------------
    // Sums are done in int so a corner near the top of RW/CW cannot wrap
    // back into the map.
    always_comb begin
        r_i     = int'(row_q) + int'(k_q) / WIN;
        c_i     = int'(col_q) + int'(k_q) % WIN;
        cur_pad = (r_i >= ROWS) || (c_i >= COLS);
        rd_addr = '0;
        if (!cur_pad) rd_addr = AW'(r_i * COLS + c_i);
    end

    assign issue = (state == ST_RD);

    fmap_ram_sp #(
        .DW    (DW),
        .DEPTH (DEPTH),
        .AW    (AW)
    ) u_ram (
        .clk   (clk),
        .we    (wr_ok),
        .waddr (bus.addr_wr),
        .wdata (bus.din),
        .re    (issue && !cur_pad),
        .raddr (rd_addr),
        .dout  (ram_dout)
    );

    // ---------------- FSM ----------------
    always_ff @(posedge clk or posedge rst) begin
        if (rst) state <= ST_IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = state;
        case (state)
            ST_IDLE:  if (bus.req_valid)               state_nxt = ST_RD;
            ST_RD:    if (k_q == KW'(N - 1))           state_nxt = ST_DRAIN;
            ST_DRAIN: if (rd_vld && rd_lane == KW'(N - 1)) state_nxt = ST_OUT;
            ST_OUT:   if (bus.win_ready)               state_nxt = ST_IDLE;
            default:                                   state_nxt = ST_IDLE;
        endcase
    end

    assign bus.req_ready = (state == ST_IDLE);
    assign bus.win_valid = (state == ST_OUT);

    // ---------------- datapath ----------------
    // rd_* tracks the read issued last cycle so its dout can be steered to
    // the right lane; pad lanes never touched the RAM and capture zero.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            row_q   <= '0;
            col_q   <= '0;
            k_q     <= '0;
            rd_vld  <= 1'b0;
            rd_pad  <= 1'b0;
            rd_lane <= '0;
            lane_q  <= '0;
        end else begin
            if (state == ST_IDLE && bus.req_valid) begin
                row_q <= bus.req_row;
                col_q <= bus.req_col;
                k_q   <= '0;
            end else if (issue) begin
                k_q <= (k_q == KW'(N - 1)) ? '0 : k_q + 1'b1;
            end
            rd_vld  <= issue;
            rd_pad  <= cur_pad;
            rd_lane <= k_q;
            if (rd_vld)
                lane_q[rd_lane] <= rd_pad ? '0 : ram_dout;
        end
    end

    assign bus.win_data = lane_q;

endmodule

// File: tb/tb_fmap_win_ram.sv
// tb_fmap_win_ram -- directed self-checking bench for fmap_win_ram.
module tb_fmap_win_ram;
    localparam int DW   = 18;
    localparam int ROWS = 26;
    localparam int COLS = 26;
    localparam int WIN  = 2;

    logic clk = 1'b0;
    logic rst = 1'b1;
    int   vectors = 0;
    int   miscompares = 0;
    int   edge_n = 0;

    fmap_win_ram_if #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WIN(WIN)) bus ();

    fmap_win_ram #(.DW(DW), .ROWS(ROWS), .COLS(COLS), .WIN(WIN)) dut (
        .clk (clk),
        .rst (rst),
        .bus (bus)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [71:0] got, input logic [71:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
        end
    endtask

    function automatic logic [71:0] win4(input int l0, input int l1, input int l2, input int l3);
        return {18'(l3), 18'(l2), 18'(l1), 18'(l0)};
    endfunction

    // inputs change and outputs are sampled 1 time unit after each rising edge
    task automatic tick();
        @(posedge clk);
        #1;
        edge_n++;
    endtask

    task automatic accept(input int row, input int col);
        bus.req_valid = 1'b1;
        bus.req_row   = 5'(row);
        bus.req_col   = 5'(col);
        tick();
        bus.req_valid = 1'b0;
        edge_n = 0;
    endtask

    task automatic wait_valid();
        while (!bus.win_valid && edge_n < 20) tick();
    endtask

    task automatic take();
        bus.win_ready = 1'b1;
        tick();
        bus.win_ready = 1'b0;
    endtask

    task automatic full_req(input string tag, input int row, input int col, input logic [71:0] exp);
        accept(row, col);
        wait_valid();
        chk({tag, "_lat"}, 72'(edge_n), 72'd5);
        chk({tag, "_data"}, bus.win_data, exp);
        take();
        chk({tag, "_rdy"}, 72'(bus.req_ready), 72'd1);
    endtask

    initial begin
        logic [71:0] held;
        logic        seen;

        bus.wr = 1'b0; bus.addr_wr = '0; bus.din = '0; bus.frame_clr = 1'b0;
        bus.req_valid = 1'b0; bus.req_row = '0; bus.req_col = '0; bus.win_ready = 1'b0;

        // reset state
        #1;
        chk("rst_ready", 72'(bus.req_ready), 72'd1);
        chk("rst_valid", 72'(bus.win_valid), 72'd0);
        chk("rst_data",  bus.win_data, 72'd0);
        chk("rst_full",  72'(bus.frame_full), 72'd0);
        tick(); tick();
        rst = 1'b0;

        // fill the map with din = addr
        for (int a = 0; a < ROWS * COLS; a++) begin
            bus.wr = 1'b1; bus.addr_wr = 10'(a); bus.din = 18'(a);
            tick();
            if (a == ROWS * COLS - 2) chk("full_early", 72'(bus.frame_full), 72'd0);
        end
        bus.wr = 1'b0;
        chk("full_set", 72'(bus.frame_full), 72'd1);
        chk("cnt_676", 72'(dut.cnt_q), 72'd676);

        // one more write: counter saturates
        bus.wr = 1'b1; bus.addr_wr = 10'd0; bus.din = 18'd0;
        tick();
        bus.wr = 1'b0;
        chk("cnt_sat", 72'(dut.cnt_q), 72'd676);

        full_req("w00", 0, 0, win4(0, 1, 26, 27));
        full_req("w2525", 25, 25, win4(675, 0, 0, 0));
        full_req("w260", 26, 0, win4(0, 0, 0, 0));

        // stall: result held, no new request taken
        accept(1, 1);
        wait_valid();
        chk("stall_lat", 72'(edge_n), 72'd5);
        chk("stall_data", bus.win_data, win4(27, 28, 53, 54));
        held = bus.win_data;
        for (int i = 0; i < 10; i++) begin
            bus.req_valid = (i == 3);
            bus.req_row   = 5'd5;
            bus.req_col   = 5'd5;
            tick();
            chk("stall_hold", bus.win_data, held);
            chk("stall_nrdy", 72'(bus.req_ready), 72'd0);
        end
        bus.req_valid = 1'b0;
        take();
        chk("stall_rdy", 72'(bus.req_ready), 72'd1);
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.win_valid) seen = 1'b1;
        end
        chk("stall_noq", 72'(seen), 72'd0);

        // reset in the middle of RD
        accept(0, 0);
        tick(); tick();
        rst = 1'b1;
        #1;
        chk("abort_rdy",  72'(bus.req_ready), 72'd1);
        chk("abort_vld",  72'(bus.win_valid), 72'd0);
        chk("abort_full", 72'(bus.frame_full), 72'd0);
        tick();
        rst = 1'b0;
        seen = 1'b0;
        for (int i = 0; i < 8; i++) begin
            tick();
            if (bus.win_valid) seen = 1'b1;
        end
        chk("abort_nvld", 72'(seen), 72'd0);
        full_req("w00_post", 0, 0, win4(0, 1, 26, 27));

        // write addr 27 on the edge that issues lane 3's read
        accept(0, 0);
        tick(); tick(); tick();
        bus.wr = 1'b1; bus.addr_wr = 10'd27; bus.din = 18'h0ABCD;
        tick();
        bus.wr = 1'b0;
        wait_valid();
        chk("rf_lat", 72'(edge_n), 72'd5);
        chk("rf_old", bus.win_data, win4(0, 1, 26, 27));
        take();
        full_req("rf_new", 0, 0, win4(0, 1, 26, 'hABCD));

        // out-of-range write, then frame_clr with a same-cycle write
        chk("cnt_pre", 72'(dut.cnt_q), 72'd1);
        bus.wr = 1'b1; bus.addr_wr = 10'd700; bus.din = 18'h3FFFF;
        tick();
        chk("cnt_oor", 72'(dut.cnt_q), 72'd1);
        bus.frame_clr = 1'b1; bus.addr_wr = 10'd5; bus.din = 18'h31234;
        tick();
        bus.wr = 1'b0; bus.frame_clr = 1'b0;
        chk("cnt_clr", 72'(dut.cnt_q), 72'd0);
        full_req("clr_wr", 0, 4, win4(4, 'h31234, 30, 31));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end
endmodule

// File: doc/fmap_win_ram.md
FMAP_WIN_RAM -- requirements
Module: fmap_win_ram

Interface
REQ-001 SHALL have parameter DW, default 18, meaning the feature-map word width in bits.
REQ-002 SHALL have parameter ROWS, default 26, meaning the feature-map height.
REQ-003 SHALL have parameter COLS, default 26, meaning the feature-map width.
REQ-004 SHALL have parameter WIN, default 2, meaning the window edge; N = WIN*WIN elements per window.
REQ-005 SHALL derive the following local widths: DEPTH = ROWS*COLS, AW = clog2(DEPTH), RW = clog2(ROWS+WIN), CW = clog2(COLS+WIN).
REQ-006 SHALL have port clk, input, 1 bit: single clock; all state on rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, asynchronous, active-high.
REQ-008 SHALL have port wr, input, 1 bit: write strobe.
REQ-009 SHALL have port addr_wr, input, AW bits: linear write address (row*COLS+col).
REQ-010 SHALL have port din, input, DW bits: write data.
REQ-011 SHALL have port frame_clr, input, 1 bit: synchronous clear of the write counter.
REQ-012 SHALL have port frame_full, output, 1 bit: all DEPTH words written since the last clear.
REQ-013 SHALL have ports req_valid/req_ready, input/output, 1 bit each: window request handshake.
REQ-014 SHALL have ports req_row/req_col, inputs, RW/CW bits: top-left coordinate of the window.
REQ-015 SHALL have ports win_valid/win_ready, output/input, 1 bit each: window result handshake.
REQ-016 SHALL have port win_data, output, N*DW bits: lane k = r*WIN+c at bits [k*DW +: DW]; lane 0 is top-left.

Function
REQ-017 SHALL write din to addr_wr on a clock edge with wr=1 and addr_wr<DEPTH; addr_wr>=DEPTH is ignored (no write, no count).
REQ-018 SHALL count accepted writes, saturating at DEPTH, and drive frame_full=1 iff count==DEPTH.
REQ-019 SHALL zero the count on frame_clr; frame_clr wins over a same-cycle wr for the count, while the RAM write still occurs.
REQ-020 SHALL implement FSM IDLE -> RD -> DRAIN -> OUT -> IDLE; req_ready=1 only in IDLE; win_valid=1 only in OUT.
REQ-021 SHALL latch req_row/req_col on req_valid&&req_ready and enter RD.
REQ-022 SHALL issue one read per cycle in RD for k=0..N-1, in lane order; enter DRAIN after k=N-1.
REQ-023 SHALL capture each registered RAM output into lane k one cycle after its issue, and enter OUT when lane N-1 is captured.
REQ-024 SHALL assert win_valid at the (N+1)th rising edge after the accepting edge (WIN=2: 5 edges).
REQ-025 SHALL return zero for any lane with row>=ROWS or col>=COLS (padding), with no RAM access dependence.
REQ-026 SHALL hold win_data stable while win_valid=1 and win_ready=0.
REQ-027 SHALL return to IDLE on win_valid&&win_ready; req_ready=1 in the following cycle; no request is queued while busy.
REQ-028 SHALL be read-first: a same-cycle write and read of one address returns the old word.
REQ-029 SHALL allow writes in every FSM state, with no interaction other than REQ-028.

Reset
REQ-030 SHALL, on rst, go to IDLE and drive req_ready=1, win_valid=0, win_data=0, frame_full=0, count=0, immediately and asynchronously.
REQ-031 SHALL abort an in-flight window on rst with no later win_valid; RAM contents are not reset.

Structure
REQ-032 SHALL take the DW/ROWS/COLS/WIN defaults and the FSM state enum from shared package cnn_pkg.
REQ-033 SHALL instantiate one sub-module, fmap_ram_sp: 1W1R, read-first, registered dout, no reset on storage.

Verification
REQ-034 SHALL cover: write din=addr for 0..675 -> frame_full rises after the 676th write; req (0,0) -> lanes {0,1,26,27}, win_valid 5 edges after accept.
REQ-035 SHALL cover: req (25,25) -> lanes {675,0,0,0}; req (26,0) -> all lanes 0.
REQ-036 SHALL cover: win_ready low for 10 cycles -> win_data constant, req_ready=0, and a req_valid pulse is not accepted.
REQ-037 SHALL cover: write 0xABCD to address 27 in the cycle lane 3 of a req (0,0) is read -> lane 3=27; a re-request -> lane 3=0xABCD.
REQ-038 SHALL cover: rst pulsed during RD -> req_ready=1, win_valid=0, frame_full=0; re-request (0,0) after reset -> {0,1,26,27}.
REQ-039 SHALL cover: wr with addr_wr=700 -> count unchanged; frame_clr with wr in the same cycle -> count=0, word written.
